conv_stream_ctrl: RTL and testbench

Sequencer that feeds one conv layer's 3x3 line buffer/window stage. On start it reads NUM_CH stored IMG_SIZE x IMG_SIZE feature maps from a single-port SRAM and emits, per channel, a raster stream of the zero-padded (IMG_SIZE+2*PAD)² image.
- Border zeros are generated locally, with no memory read.
- Output uses a valid/ready handshake so downstream stalls are absorbed.
- Sits between the feature-map SRAM and the line buffer's pixel_in/valid_in.

---
 rtl/conv_pkg.sv | 18 +
 rtl/pad_pos_counter.sv | 74 +++++++
 rtl/conv_stream_ctrl.sv | 171 +++++++++++++++++
 tb/tb_conv_stream_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv layer streaming sequencer.
package conv_pkg;

  localparam int PIX_W = 16;

  typedef logic signed [PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic int padded_size(input int img_size, input int pad);
    return img_size + 2 * pad;
  endfunction

endpackage

// File: rtl/pad_pos_counter.sv
// Raster walker over the zero-padded image: column fastest, then row, then channel.
module pad_pos_counter
  import conv_pkg::*;
#(
  parameter int IMG_SIZE = 28,
  parameter int PAD      = 1,
  parameter int NUM_CH   = 4,
  parameter int POS_W    = 5,
  parameter int CH_W     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  output logic [POS_W-1:0] r,
  output logic [POS_W-1:0] c,
  output logic [CH_W-1:0]  ch,
  output logic             is_pad,
  output logic             is_last_pos
);

  localparam int P = padded_size(IMG_SIZE, PAD);

  logic [POS_W-1:0] r_q, r_d;
  logic [POS_W-1:0] c_q, c_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    r_d  = r_q;
    c_d  = c_q;
    ch_d = ch_q;
    if (clear) begin
      r_d  = '0;
      c_d  = '0;
      ch_d = '0;
    end else if (advance) begin
      if (c_q == POS_W'(P - 1)) begin
        c_d = '0;
        if (r_q == POS_W'(P - 1)) begin
          r_d  = '0;
          ch_d = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
        end else begin
          r_d = r_q + 1'b1;
        end
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample their inputs from the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q  <= '0;
      c_q  <= '0;
      ch_q <= '0;
    end else begin
      r_q  <= r_d;
      c_q  <= c_d;
      ch_q <= ch_d;
    end
  end

  assign r  = r_q;
  assign c  = c_q;
  assign ch = ch_q;

  assign is_pad = (r_q < POS_W'(PAD)) || (r_q >= POS_W'(IMG_SIZE + PAD)) ||
                  (c_q < POS_W'(PAD)) || (c_q >= POS_W'(IMG_SIZE + PAD));

  assign is_last_pos = (r_q == POS_W'(P - 1)) && (c_q == POS_W'(P - 1));

endmodule

// File: rtl/conv_stream_ctrl.sv
// Streams NUM_CH zero-padded feature maps from SRAM to the 3x3 line buffer
// through an issue -> P1 -> output pipeline with valid/ready backpressure.
module conv_stream_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_SIZE = 28,
  parameter int PAD      = 1,
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 12,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  pixel_t            mem_rd_data,
  output pixel_t            pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic [CH_W-1:0]   ch_idx,
  output logic              busy,
  output logic              done
);

  localparam int P     = padded_size(IMG_SIZE, PAD);
  localparam int POS_W = $clog2(P + 1);

  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic            p1_valid_q, p1_valid_d;
  logic            p1_pad_q, p1_pad_d;
  logic [CH_W-1:0] p1_ch_q, p1_ch_d;
  logic            p1_last_q, p1_last_d;

  logic            out_valid_q, out_valid_d;
  pixel_t          out_pix_q, out_pix_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic            out_last_q, out_last_d;

  logic            cnt_clear;
  logic            issue;
  logic            out_load;
  logic            p1_load;
  logic            drain_empty;
  logic            final_pos;
  logic [CH_W-1:0] pos_ch;
  logic            pos_is_pad;
  logic            pos_is_last;

  pad_pos_counter #(
    .IMG_SIZE(IMG_SIZE),
    .PAD     (PAD),
    .NUM_CH  (NUM_CH),
    .POS_W   (POS_W),
    .CH_W    (CH_W)
  ) u_pos (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (cnt_clear),
    .advance    (issue),
    .r          (),
    .c          (),
    .ch         (pos_ch),
    .is_pad     (pos_is_pad),
    .is_last_pos(pos_is_last)
  );

  // Backpressure ripples from the output register back to the issue stage.
  assign out_load    = !out_valid_q || pix_ready;
  assign p1_load     = !p1_valid_q || out_load;
  assign issue       = (state_q == RUN) && p1_load;
  assign drain_empty = !p1_valid_q && !out_valid_q;
  assign final_pos   = pos_is_last && (pos_ch == CH_W'(NUM_CH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          cnt_clear = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (issue && final_pos) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_empty) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          busy = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM address runs across channels; it only restarts when a new run begins.
  always_comb begin
    mem_rd_en = issue && !pos_is_pad;
    addr_d    = addr_q;
    if (state_q == IDLE && start) addr_d = '0;
    else if (mem_rd_en)           addr_d = addr_q + 1'b1;
  end

  // mem_rd_data stays stable while P1 holds a read, because the next read is
  // only issued on the same edge that moves P1 into the output register.
  always_comb begin
    p1_valid_d  = p1_valid_q;
    p1_pad_d    = p1_pad_q;
    p1_ch_d     = p1_ch_q;
    p1_last_d   = p1_last_q;
    out_valid_d = out_valid_q;
    out_pix_d   = out_pix_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    if (p1_load) begin
      p1_valid_d = issue;
      p1_pad_d   = pos_is_pad;
      p1_ch_d    = pos_ch;
      p1_last_d  = pos_is_last;
    end
    if (out_load) begin
      out_valid_d = p1_valid_q;
      out_pix_d   = (p1_valid_q && !p1_pad_q) ? mem_rd_data : '0;
      out_ch_d    = p1_ch_q;
      out_last_d  = p1_valid_q && p1_last_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      p1_valid_q  <= 1'b0;
      p1_pad_q    <= 1'b0;
      p1_ch_q     <= '0;
      p1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      p1_valid_q  <= p1_valid_d;
      p1_pad_q    <= p1_pad_d;
      p1_ch_q     <= p1_ch_d;
      p1_last_q   <= p1_last_d;
      out_valid_q <= out_valid_d;
      out_pix_q   <= out_pix_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
    end
  end

  assign mem_addr  = addr_q;
  assign pix_out   = out_pix_q;
  assign pix_valid = out_valid_q;
  assign pix_last  = out_last_q;
  assign ch_idx    = out_ch_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl: 28x28 maps, PAD=1, 4 channels, SRAM[a]=a+1.
module tb_conv_stream_ctrl;

  localparam int IMG    = 28;
  localparam int PADW   = 1;
  localparam int NCH    = 4;
  localparam int PSZ    = IMG + 2 * PADW;
  localparam int P2     = PSZ * PSZ;
  localparam int TOTAL  = NCH * P2;
  localparam int NREADS = NCH * IMG * IMG;
  localparam int BUDGET = 20000;

  logic               clk;
  logic               reset_n;
  logic               start;
  logic               mem_rd_en;
  logic [11:0]        mem_addr;
  logic signed [15:0] mem_rd_data;
  logic signed [15:0] pix_out;
  logic               pix_valid;
  logic               pix_ready;
  logic               pix_last;
  logic [1:0]         ch_idx;
  logic               busy;
  logic               done;

  int n_total;
  int n_bad;

  conv_stream_ctrl #(
    .IMG_SIZE(IMG),
    .PAD     (PADW),
    .NUM_CH  (NCH),
    .ADDR_W  (12)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .pix_out    (pix_out),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .ch_idx     (ch_idx),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM holding a+1 at address a; data holds between reads.
  initial mem_rd_data = '0;
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 16'(mem_addr + 12'd1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected value of accepted pixel number idx across the whole run.
  function automatic int exp_pix(input int idx);
    int ch = idx / P2;
    int k  = idx % P2;
    int r  = k / PSZ;
    int c  = k % PSZ;
    if (r < PADW || r >= IMG + PADW || c < PADW || c >= IMG + PADW) return 0;
    return ch * IMG * IMG + (r - PADW) * IMG + (c - PADW) + 1;
  endfunction

  function automatic logic ready_for(input int mode, input int t);
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return (t >= 20);
    return 1'b1;
  endfunction

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 32'(pix_valid), 0);
    check({tag, "_pix"}, 32'(pix_out), 0);
    check({tag, "_last"}, 32'(pix_last), 0);
    check({tag, "_ch"}, 32'(ch_idx), 0);
    check({tag, "_rden"}, 32'(mem_rd_en), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Runs one start-to-done stream. mode: 0 ready held high, 1 random ready,
  // 2 ready low for 20 cycles after start. poke re-pulses start mid-run and in
  // DRAIN. abort_at >= 0 asserts reset_n once that many pixels were accepted.
  task automatic run_stream(input string name, input int mode, input bit poke, input int abort_at);
    int  n_acc, n_rd, n_rd_stall, n_done, first_valid, valid_cycles, last_hs, done_t;
    bit  stall_prev, aborted;
    logic signed [15:0] prev_pix;
    logic [1:0] prev_ch;
    logic prev_last;
    int  t;

    n_acc = 0; n_rd = 0; n_rd_stall = 0; n_done = 0; first_valid = -1;
    valid_cycles = 0; last_hs = -1; done_t = -1; stall_prev = 0; aborted = 0;
    prev_pix = '0; prev_ch = '0; prev_last = 1'b0;

    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pix_ready = ready_for(mode, 0);

    for (t = 0; t < BUDGET; t++) begin
      @(negedge clk);
      if (t == 0) check({name, "_busy_after_start"}, 32'(busy), 1);

      if (mem_rd_en) begin
        check($sformatf("%s_rdaddr[%0d]", name, n_rd), 32'(mem_addr), 32'(n_rd));
        if (n_rd == 2 * IMG * IMG) check({name, "_ch2_first_addr"}, 32'(mem_addr), 1568);
        if (t < 20) n_rd_stall++;
        n_rd++;
      end

      if (stall_prev) begin
        check({name, "_stall_valid"}, 32'(pix_valid), 1);
        check({name, "_stall_pix"}, 32'(pix_out), 32'(prev_pix));
        check({name, "_stall_ch"}, 32'(ch_idx), 32'(prev_ch));
        check({name, "_stall_last"}, 32'(pix_last), 32'(prev_last));
      end

      if (pix_valid) begin
        if (first_valid < 0) first_valid = t;
        valid_cycles++;
      end

      if (pix_valid && pix_ready) begin
        check($sformatf("%s_pix[%0d]", name, n_acc), 32'(pix_out), 32'(exp_pix(n_acc)));
        check($sformatf("%s_ch[%0d]", name, n_acc), 32'(ch_idx), 32'(n_acc / P2));
        check($sformatf("%s_last[%0d]", name, n_acc), 32'(pix_last), 32'((n_acc % P2) == P2 - 1));
        n_acc++;
        last_hs = t;
      end

      stall_prev = pix_valid && !pix_ready;
      prev_pix   = pix_out;
      prev_ch    = ch_idx;
      prev_last  = pix_last;

      if (done) begin
        n_done++;
        done_t = t;
        check({name, "_done_after_last_hs"}, 32'(t - last_hs), 1);
        check({name, "_busy_in_done"}, 32'(busy), 0);
      end

      if (abort_at >= 0 && n_acc >= abort_at) begin
        reset_n = 1'b0;
        #1;
        check_outputs_zero({name, "_async_rst"});
        aborted = 1;
        break;
      end

      if (n_done > 0 && t >= done_t + 4) break;

      @(posedge clk);
      #1;
      pix_ready = ready_for(mode, t + 1);
      start = poke && ((t + 1 == 1000) || (t + 1 == TOTAL) || (t + 1 == TOTAL + 2));
    end

    start = 1'b0;
    if (aborted) begin
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      pix_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check({name, "_post_abort_done"}, 32'(done), 0);
        check({name, "_post_abort_busy"}, 32'(busy), 0);
      end
      @(posedge clk);
      #1;
    end else begin
      check({name, "_timeout"}, 32'(n_done > 0), 1);
      check({name, "_pix_count"}, 32'(n_acc), TOTAL);
      check({name, "_rd_count"}, 32'(n_rd), NREADS);
      check({name, "_done_count"}, 32'(n_done), 1);
      check({name, "_idle_after"}, 32'(busy || pix_valid), 0);
      if (mode == 0) begin
        check({name, "_first_valid_lat"}, 32'(first_valid), 2);
        check({name, "_valid_cycles"}, 32'(valid_cycles), TOTAL);
        check({name, "_no_bubbles"}, 32'(last_hs - first_valid + 1), TOTAL);
      end
      if (mode == 2) check({name, "_reads_before_stall_le1"}, 32'(n_rd_stall <= 1), 1);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b1;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_stream("cont", 0, 1'b0, -1);
    run_stream("rand", 1, 1'b0, -1);
    run_stream("stall", 2, 1'b0, -1);
    run_stream("poke", 0, 1'b1, -1);
    run_stream("abort", 0, 1'b0, 400);
    run_stream("rerun", 0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
